pipe_hazard_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage pipelined CPU; successor to the combinational

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pipe_hazard_unit_if.sv | 37 +++
 rtl/hazard_sb_entry.sv | 20 ++
 rtl/pipe_hazard_unit.sv | 101 ++++++++++
 tb/tb_pipe_hazard_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: forward-select codes, scoreboard entry, forward helper
package cpu_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              load;
    } sb_entry_t;

    // A load sitting in MEM has no data yet, so it is never a forward source there.
    function automatic logic [1:0] fwd_sel(sb_entry_t mem, sb_entry_t wb, logic [REG_AW-1:0] src);
        if (mem.valid && mem.regwrite && !mem.load && mem.rd != '0 && mem.rd == src)
            return FWD_MEM;
        if (wb.valid && wb.regwrite && wb.rd != '0 && wb.rd == src)
            return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// rtl/pipe_hazard_unit_if.sv - ID-stage hazard inputs and pipeline control outputs
interface pipe_hazard_unit_if #(
    parameter int CNT_W = 16
);
    import cpu_pkg::*;

    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_use_rs_i;
    logic              id_use_rt_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              ex_branch_i;
    logic              mdu_busy_i;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              stall_o;
    logic              flush_o;
    logic              freeze_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_use_rs_i, id_use_rt_i,
               id_regwrite_i, id_memread_i, ex_branch_i, mdu_busy_i,
        input  fwd_a_o, fwd_b_o, stall_o, flush_o, freeze_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_use_rs_i, id_use_rt_i,
               id_regwrite_i, id_memread_i, ex_branch_i, mdu_busy_i,
        output fwd_a_o, fwd_b_o, stall_o, flush_o, freeze_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/hazard_sb_entry.sv
// rtl/hazard_sb_entry.sv - one scoreboard stage: hold, load, or collapse to a bubble
module hazard_sb_entry
    import cpu_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      hold_i,
    input  logic      load_i,
    input  sb_entry_t d_i,
    output sb_entry_t q_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            q_o <= '0;
        else if (!hold_i)
            q_o <= load_i ? d_i : '0;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - scoreboard-based forwarding, load-use stall, flush and freeze control
module pipe_hazard_unit
    import cpu_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    pipe_hazard_unit_if.slave hz
);

    localparam logic [1:0] LD_RELOAD = 2'(LOAD_LAT - 1);

    sb_entry_t        id_e;
    sb_entry_t        ex_e;
    sb_entry_t        mem_e;
    sb_entry_t        wb_e;
    logic             freeze;
    logic             flush;
    logic             stall;
    logic             load_use;
    logic             ex_load;
    logic [1:0]       ld_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             unused_fields;

    assign id_e = '{valid:    1'b1,
                    rs:       hz.id_rs_i,
                    rt:       hz.id_rt_i,
                    rd:       hz.id_rd_i,
                    regwrite: hz.id_regwrite_i,
                    load:     hz.id_memread_i};

    assign freeze   = hz.mdu_busy_i;
    assign flush    = hz.ex_branch_i && !freeze;
    assign load_use = hz.id_valid_i && ex_e.valid && ex_e.load && ex_e.rd != '0 &&
                      ((hz.id_use_rs_i && hz.id_rs_i == ex_e.rd) ||
                       (hz.id_use_rt_i && hz.id_rt_i == ex_e.rd));
    // The countdown keeps the stall alive after the load has left EX when LOAD_LAT > 1.
    assign stall    = (load_use || ld_cnt != 2'd0) && !freeze && !flush;
    assign ex_load  = hz.id_valid_i && !stall && !flush;

    hazard_sb_entry u_ex (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .hold_i  (freeze),
        .load_i  (ex_load),
        .d_i     (id_e),
        .q_o     (ex_e)
    );

    hazard_sb_entry u_mem (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .hold_i  (freeze),
        .load_i  (1'b1),
        .d_i     (ex_e),
        .q_o     (mem_e)
    );

    hazard_sb_entry u_wb (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .hold_i  (freeze),
        .load_i  (1'b1),
        .d_i     (mem_e),
        .q_o     (wb_e)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ld_cnt    <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!freeze) begin
            if (flush)
                ld_cnt <= 2'd0;
            else if (load_use)
                ld_cnt <= LD_RELOAD;
            else if (ld_cnt != 2'd0)
                ld_cnt <= ld_cnt - 2'd1;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.fwd_a_o     = fwd_sel(mem_e, wb_e, ex_e.rs);
    assign hz.fwd_b_o     = fwd_sel(mem_e, wb_e, ex_e.rt);
    assign hz.stall_o     = stall;
    assign hz.flush_o     = flush;
    assign hz.freeze_o    = freeze;
    assign hz.stall_cnt_o = stall_cnt;
    assign hz.flush_cnt_o = flush_cnt;

    assign unused_fields = ^{mem_e.rs, mem_e.rt, wb_e.rs, wb_e.rt, wb_e.load};

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed bench with an instruction-history model of the hazard unit
module tb_pipe_hazard_unit;

    localparam int LOAD_LAT = 1;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct {
        bit v;
        int rs;
        int rt;
        int rd;
        bit rw;
        bit ld;
    } ins_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    ins_t hist[$];
    int   m_left;
    int   m_scnt;
    int   m_fcnt;
    bit   e_det;
    bit   e_stall;
    bit   e_flush;

    pipe_hazard_unit_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_unit #(.LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .hz      (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic ins_t bubble();
        ins_t b;
        b.v = 0; b.rs = 0; b.rt = 0; b.rd = 0; b.rw = 0; b.ld = 0;
        return b;
    endfunction

    // Producers are searched youngest first; a load still in MEM is not a source.
    function automatic int fwd_of(int src);
        ins_t mem;
        ins_t wb;
        mem = hist[1];
        wb  = hist[0];
        if (mem.v && mem.rw && !mem.ld && mem.rd != 0 && mem.rd == src) return 2;
        if (wb.v && wb.rw && wb.rd != 0 && wb.rd == src) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(bubble());
        m_left = 0;
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    task automatic model_check();
        ins_t ex;
        bit   busy;
        if (!rst_n) model_reset();
        ex   = hist[2];
        busy = hz.mdu_busy_i;
        e_det = hz.id_valid_i && ex.v && ex.ld && ex.rd != 0 &&
                ((hz.id_use_rs_i && int'(hz.id_rs_i) == ex.rd) ||
                 (hz.id_use_rt_i && int'(hz.id_rt_i) == ex.rd));
        e_flush = hz.ex_branch_i && !busy;
        e_stall = (e_det || m_left > 0) && !busy && !e_flush;
        chk("fwd_a", int'(hz.fwd_a_o), fwd_of(ex.rs));
        chk("fwd_b", int'(hz.fwd_b_o), fwd_of(ex.rt));
        chk("stall", int'(hz.stall_o), int'(e_stall));
        chk("flush", int'(hz.flush_o), int'(e_flush));
        chk("freeze", int'(hz.freeze_o), int'(busy));
        chk("stall_cnt", int'(hz.stall_cnt_o), m_scnt);
        chk("flush_cnt", int'(hz.flush_cnt_o), m_fcnt);
    endtask

    task automatic model_step();
        ins_t n;
        if (!rst_n) begin
            model_reset();
        end else if (!hz.mdu_busy_i) begin
            if (e_flush) m_left = 0;
            else if (e_det) m_left = LOAD_LAT - 1;
            else if (m_left > 0) m_left--;
            if (e_stall) m_scnt = (m_scnt < CNT_MAX) ? m_scnt + 1 : CNT_MAX;
            if (e_flush) m_fcnt = (m_fcnt < CNT_MAX) ? m_fcnt + 1 : CNT_MAX;
            n = bubble();
            if (hz.id_valid_i && !e_stall && !e_flush) begin
                n.v  = 1;
                n.rs = int'(hz.id_rs_i);
                n.rt = int'(hz.id_rt_i);
                n.rd = int'(hz.id_rd_i);
                n.rw = hz.id_regwrite_i;
                n.ld = hz.id_memread_i;
            end
            hist.push_back(n);
            void'(hist.pop_front());
        end
    endtask

    task automatic cyc(input bit v, input int rs, input int rt, input int rd,
                       input bit urs, input bit urt, input bit rw, input bit mr,
                       input bit br, input bit busy, input bit rst_next);
        @(posedge clk);
        model_step();
        #1;
        rst_n            = rst_next;
        hz.id_valid_i    = v;
        hz.id_rs_i       = 5'(rs);
        hz.id_rt_i       = 5'(rt);
        hz.id_rd_i       = 5'(rd);
        hz.id_use_rs_i   = urs;
        hz.id_use_rt_i   = urt;
        hz.id_regwrite_i = rw;
        hz.id_memread_i  = mr;
        hz.ex_branch_i   = br;
        hz.mdu_busy_i    = busy;
        @(negedge clk);
        model_check();
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic alu(input int rs, input int rt, input int rd);
        cyc(1, rs, rt, rd, 1, 1, 1, 0, 0, 0, 1);
    endtask

    task automatic lw(input int base, input int rd);
        cyc(1, base, 0, rd, 1, 0, 1, 1, 0, 0, 1);
    endtask

    initial begin
        hz.id_valid_i = 0; hz.id_rs_i = '0; hz.id_rt_i = '0; hz.id_rd_i = '0;
        hz.id_use_rs_i = 0; hz.id_use_rt_i = 0; hz.id_regwrite_i = 0;
        hz.id_memread_i = 0; hz.ex_branch_i = 0; hz.mdu_busy_i = 0;
        model_reset();
        e_det = 0; e_stall = 0; e_flush = 0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_fwd_a", int'(hz.fwd_a_o), 0);
        chk("rst_stall", int'(hz.stall_o), 0);
        chk("rst_flush_cnt", int'(hz.flush_cnt_o), 0);
        nop();

        alu(1, 2, 3); alu(3, 1, 4); nop();
        chk("t1_fwd_a", int'(hz.fwd_a_o), 2);
        chk("t1_fwd_b", int'(hz.fwd_b_o), 0);

        alu(1, 2, 3); nop(); alu(3, 3, 5); nop();
        chk("t2_wb_fwd_a", int'(hz.fwd_a_o), 1);
        chk("t2_wb_fwd_b", int'(hz.fwd_b_o), 1);
        alu(1, 2, 3); alu(1, 2, 3); alu(3, 3, 6); nop();
        chk("t2_mem_wins", int'(hz.fwd_a_o), 2);

        lw(1, 2); alu(2, 2, 4);
        chk("t3_stall", int'(hz.stall_o), 1);
        alu(2, 2, 4);
        chk("t3_stall_end", int'(hz.stall_o), 0);
        chk("t3_stall_cnt", int'(hz.stall_cnt_o), 1);
        nop();
        chk("t3_fwd_a", int'(hz.fwd_a_o), 1);
        chk("t3_fwd_b", int'(hz.fwd_b_o), 1);

        lw(1, 0); alu(0, 0, 4);
        chk("t4_no_stall", int'(hz.stall_o), 0);
        alu(1, 2, 0); alu(0, 0, 7); nop();
        chk("t4_r0_fwd", int'(hz.fwd_a_o), 0);

        lw(1, 2); cyc(1, 2, 2, 4, 1, 1, 1, 0, 1, 0, 1);
        chk("t5_flush", int'(hz.flush_o), 1);
        chk("t5_stall", int'(hz.stall_o), 0);
        nop();
        chk("t5_flush_cnt", int'(hz.flush_cnt_o), 1);
        cyc(1, 1, 0, 2, 1, 0, 1, 1, 1, 0, 1);
        alu(2, 2, 4);
        chk("t5_bubble", int'(hz.stall_o), 0);

        lw(1, 2);
        for (int i = 0; i < 3; i++) cyc(1, 2, 2, 4, 1, 1, 1, 0, 0, 1, 1);
        chk("t6_freeze", int'(hz.freeze_o), 1);
        chk("t6_frozen_stall", int'(hz.stall_o), 0);
        chk("t6_cnt_hold", int'(hz.stall_cnt_o), 1);
        alu(2, 2, 4);
        chk("t6_stall_resume", int'(hz.stall_o), 1);
        cyc(1, 2, 2, 4, 1, 1, 1, 0, 0, 1, 1);
        chk("t6_cnt_after", int'(hz.stall_cnt_o), 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t6_rst_scnt", int'(hz.stall_cnt_o), 0);
        chk("t6_rst_fcnt", int'(hz.flush_cnt_o), 0);
        nop();

        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        nop();
        chk("sat_flush_cnt", int'(hz.flush_cnt_o), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
